// File: rtl/pll_frac_divider.sv
// Multi-channel fractional clock synthesiser: each channel toggles CLK_out on
// every phase-accumulator wrap, with shadowed reconfiguration and a lock flag.
module pll_frac_divider #(
  parameter int CH           = 2,
  parameter int MW           = 4,
  parameter int NW           = 4,
  parameter int DEF_M        = 3,
  parameter int DEF_N        = 10,
  parameter int LOCK_PERIODS = 4
) (
  input  logic             CLK_exit,
  input  logic             rst_n,
  input  logic [CH-1:0]    ch_en,
  input  logic [CH*MW-1:0] cfg_M,
  input  logic [CH*NW-1:0] cfg_N,
  input  logic [CH-1:0]    cfg_load,
  output logic [CH-1:0]    CLK_out,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    pend,
  output logic [CH-1:0]    cfg_err,
  output logic [CH-1:0]    lock
);

  localparam int AW = NW + 1;
  localparam int CW = $clog2(LOCK_PERIODS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t          st;
    logic [MW-1:0]   m_in, m_act, m_pnd;
    logic [NW-1:0]   n_in, n_act, n_pnd;
    logic [AW-1:0]   acc, s;
    logic [CW-1:0]   cnt;
    logic            clk_q, tick_q, pend_q, err_q;
    logic            wrap, fall, load_ok, ld;

    assign m_in    = cfg_M[g*MW +: MW];
    assign n_in    = cfg_N[g*NW +: NW];
    assign load_ok = (m_in != '0) && (n_in != '0) && (AW'(m_in) <= AW'(n_in));
    assign ld      = cfg_load[g] & load_ok;
    assign s       = acc + AW'(m_act);
    assign wrap    = (s >= AW'(n_act));
    // Only a high-to-low wrap may apply a pending config or count a period.
    assign fall    = wrap & clk_q;

    always_ff @(posedge CLK_exit or negedge rst_n) begin
      if (!rst_n) begin
        st     <= IDLE;
        acc    <= '0;
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        err_q  <= 1'b0;
        m_act  <= MW'(DEF_M);
        n_act  <= NW'(DEF_N);
        m_pnd  <= MW'(DEF_M);
        n_pnd  <= NW'(DEF_N);
      end else begin
        tick_q <= 1'b0;
        err_q  <= cfg_load[g] & ~load_ok;
        if (ld) begin
          m_pnd  <= m_in;
          n_pnd  <= n_in;
          pend_q <= 1'b1;
        end
        case (st)
          IDLE: begin
            acc   <= '0;
            clk_q <= 1'b0;
            cnt   <= '0;
            if (pend_q) begin
              m_act <= m_pnd;
              n_act <= n_pnd;
              if (!ld) pend_q <= 1'b0;
            end
            if (ch_en[g]) st <= RUN;
          end
          default: begin
            if (st == RUN && !ch_en[g] && !clk_q) begin
              st  <= IDLE;
              acc <= '0;
              cnt <= '0;
            end else begin
              st  <= ch_en[g] ? RUN : DRAIN;
              acc <= wrap ? (s - AW'(n_act)) : s;
              if (wrap) begin
                clk_q  <= ~clk_q;
                tick_q <= 1'b1;
              end
              if (fall && pend_q) begin
                m_act <= m_pnd;
                n_act <= n_pnd;
                acc   <= '0;
                if (!ld) pend_q <= 1'b0;
              end
              // Draining finishes the high phase, then parks the channel.
              if (fall && !ch_en[g]) begin
                st  <= IDLE;
                acc <= '0;
              end
              if (!ch_en[g] || st != RUN || (fall && pend_q))
                cnt <= '0;
              else if (fall && cnt != CW'(LOCK_PERIODS))
                cnt <= cnt + CW'(1);
            end
          end
        endcase
      end
    end

    assign CLK_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pend[g]    = pend_q;
    assign cfg_err[g] = err_q;
    assign lock[g]    = (cnt == CW'(LOCK_PERIODS));
  end

endmodule

// File: tb/tb_pll_frac_divider.sv
// Directed bench for pll_frac_divider: vector tables for the default run and
// config rejection, hand-written sequences for shadowing, drain and reset.
module tb_pll_frac_divider;
  localparam int CH = 2, MW = 4, NW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    ch_en, cfg_load;
  logic [CH*MW-1:0] cfg_M;
  logic [CH*NW-1:0] cfg_N;
  logic [CH-1:0]    CLK_out, tick, pend, cfg_err, lock;

  int passed = 0;
  int total  = 0;

  pll_frac_divider #(.CH(CH), .MW(MW), .NW(NW), .DEF_M(3), .DEF_N(10), .LOCK_PERIODS(4)) dut (
    .CLK_exit(clk), .rst_n(rst_n), .ch_en(ch_en), .cfg_M(cfg_M), .cfg_N(cfg_N),
    .cfg_load(cfg_load), .CLK_out(CLK_out), .tick(tick), .pend(pend),
    .cfg_err(cfg_err), .lock(lock)
  );

  always #5 clk = ~clk;

  typedef struct {int e; logic ck; logic lk;} run_vec_t;
  typedef struct {logic [3:0] m; logic [3:0] n;} cfg_vec_t;
  run_vec_t run_tbl[11];
  cfg_vec_t bad_tbl[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [3:0] m, input logic [3:0] n);
    cfg_M[3:0]  = m;
    cfg_N[3:0]  = n;
    cfg_load[0] = 1'b1;
  endtask

  // Enable channel 0 with default M=3/N=10 and walk edges 1..27 against the table.
  task automatic run_default(input string tag);
    int idx = 0;
    int ticks = 0;
    ch_en[0] = 1'b1;
    step();
    chk({tag, "_pend_start"}, pend[0], 0);
    for (int e = 1; e <= 27; e++) begin
      step();
      if (e <= 20 && tick[0]) ticks++;
      if (idx < 11 && run_tbl[idx].e == e) begin
        chk($sformatf("%s_clk_e%0d", tag, e), CLK_out[0], run_tbl[idx].ck);
        chk($sformatf("%s_lock_e%0d", tag, e), lock[0], run_tbl[idx].lk);
        idx++;
      end
    end
    chk({tag, "_ticks20"}, ticks, 6);
    chk({tag, "_ch1_idle"}, {CLK_out[1], lock[1], tick[1]}, 0);
  endtask

  // Step until CLK_out[0] goes 1->0; returns 0 if the budget runs out.
  task automatic wait_fall(input int budget, output bit ok, output bit pend_held);
    logic prev = CLK_out[0];
    ok = 0;
    pend_held = 1;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (prev && !CLK_out[0]) ok = 1;
      else if (!pend[0]) pend_held = 0;
      prev = CLK_out[0];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok, held;
    int ticks;
    run_tbl[0]  = '{3, 1'b0, 1'b0};
    run_tbl[1]  = '{4, 1'b1, 1'b0};
    run_tbl[2]  = '{6, 1'b1, 1'b0};
    run_tbl[3]  = '{7, 1'b0, 1'b0};
    run_tbl[4]  = '{10, 1'b1, 1'b0};
    run_tbl[5]  = '{13, 1'b1, 1'b0};
    run_tbl[6]  = '{14, 1'b0, 1'b0};
    run_tbl[7]  = '{17, 1'b1, 1'b0};
    run_tbl[8]  = '{20, 1'b0, 1'b0};
    run_tbl[9]  = '{26, 1'b1, 1'b0};
    run_tbl[10] = '{27, 1'b0, 1'b1};
    bad_tbl[0]  = '{4'd0, 4'd5};
    bad_tbl[1]  = '{4'd7, 4'd5};
    bad_tbl[2]  = '{4'd5, 4'd0};

    rst_n = 1'b0; ch_en = '0; cfg_load = '0; cfg_M = '0; cfg_N = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {CLK_out, tick, pend, cfg_err, lock}, 0);
    #3 rst_n = 1'b1;

    run_default("default");

    // Rejected loads: each pulses cfg_err, leaves pend and the period alone.
    for (int i = 0; i < 3; i++) begin
      load0(bad_tbl[i].m, bad_tbl[i].n);
      step();
      chk($sformatf("bad%0d_err", i), cfg_err[0], 1);
      chk($sformatf("bad%0d_pend", i), pend[0], 0);
      cfg_load[0] = 1'b0;
      step();
      chk($sformatf("bad%0d_err_clear", i), cfg_err[0], 0);
    end
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tick[0]) ticks++;
    end
    chk("bad_ticks30", ticks, 9);
    chk("bad_lock_kept", lock[0], 1);

    // Shadowed load M=N=5 applies at the next falling edge.
    load0(4'd5, 4'd5);
    step();
    chk("m5_pend_set", pend[0], 1);
    chk("m5_no_err", cfg_err[0], 0);
    cfg_load[0] = 1'b0;
    wait_fall(20, ok, held);
    chk("m5_fall_seen", ok, 1);
    chk("m5_pend_held", held, 1);
    chk("m5_applied", {pend[0], lock[0]}, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("m5_clk_k%0d", k), CLK_out[0], k % 2);
      if (k >= 7) chk($sformatf("m5_lock_k%0d", k), lock[0], (k == 8));
    end

    // Back to M=3/N=10, then drop ch_en during a high phase.
    load0(4'd3, 4'd10);
    step();
    chk("d_pend_set", pend[0], 1);
    cfg_load[0] = 1'b0;
    wait_fall(6, ok, held);
    chk("d_fall_seen", ok, 1);
    chk("d_applied", pend[0], 0);
    step(); step(); step();
    chk("d_clk_a3", CLK_out[0], 0);
    step();
    chk("d_clk_a4", CLK_out[0], 1);
    ch_en[0] = 1'b0;
    step();
    chk("drain_a5", CLK_out[0], 1);
    step();
    chk("drain_a6", CLK_out[0], 1);
    step();
    chk("drain_a7", {CLK_out[0], tick[0], lock[0]}, 3'b010);
    step();
    chk("drain_idle", {CLK_out[0], tick[0]}, 0);

    // Re-enable: first rise after edge 4 again.
    ch_en[0] = 1'b1;
    step();
    step(); step(); step();
    chk("re_clk_e3", CLK_out[0], 0);
    step();
    chk("re_clk_e4", CLK_out[0], 1);

    // Load A (5/5) early, load B (1/2) exactly on the apply edge.
    load0(4'd5, 4'd5);
    step();
    chk("ab_pendA", pend[0], 1);
    cfg_load[0] = 1'b0;
    step();
    load0(4'd1, 4'd2);
    step();
    chk("ab_e7", {CLK_out[0], pend[0]}, 2'b01);
    cfg_load[0] = 1'b0;
    step();
    chk("ab_e8", {CLK_out[0], pend[0]}, 2'b11);
    step();
    chk("ab_e9", {CLK_out[0], pend[0]}, 2'b00);
    step();
    chk("ab_e10", CLK_out[0], 0);
    step();
    chk("ab_e11", CLK_out[0], 1);
    step();
    chk("ab_e12", CLK_out[0], 1);
    step();
    chk("ab_e13", CLK_out[0], 0);

    // Async reset mid-high-phase with a pending config.
    load0(4'd2, 4'd3);
    step();
    chk("rst_pre_pend", {CLK_out[0], pend[0]}, 2'b01);
    cfg_load[0] = 1'b0;
    step();
    chk("rst_pre_high", {CLK_out[0], pend[0]}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {CLK_out, tick, pend, cfg_err, lock}, 0);
    #3 rst_n = 1'b1;
    run_default("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
